psram_qpi_ctrl: RTL and testbench
=================================

// Module: psram_qpi_ctrl
// PURPOSE
//  Parametrised QPI PSRAM controller for the Tang Nano PSRAM path.
//  Runs the power-up sequence itself (delay, RSTEN 0x66, RST 0x99, SPI2QPI 0x35),
//  then serves valid/ready read/write burst commands of 1..MAX_BURST words.
//  Uses split SIO out/oe/in pins; the tri-state buffers sit in the top level.
//  PSRAM SCLK is driven as ~mem_clk by the top level; all logic here is posedge.
// PARAMETERS
//  DATA_W       16     word width in bits; must be a multiple of 4 (DATA_W/4 nibbles per word)
//  INIT_CYCLES  12800  reset-release delay, in cycles, before RSTEN (~150us at 84MHz)
//  READ_WAIT    6      QPI read wait cycles between the last address nibble and the first data nibble
//  MAX_BURST    8      maximum words per command
//  LEN_W        3      cmd_len width; must satisfy 2**LEN_W >= MAX_BURST
// PORTS
//  mem_clk    in   1       system / memory clock
//  rst        in   1       asynchronous reset, active-high
//  cmd_valid  in   1       command request
//  cmd_ready  out  1       controller can accept a command
//  cmd_write  in   1       1 = write, 0 = read
//  cmd_addr   in   24      start byte address
//  cmd_len    in   LEN_W   number of words minus 1
//  wr_data    in   DATA_W  write word; sampled in every cycle where wr_ready=1
//  wr_ready   out  1       1-cycle pulse: wr_data consumed this cycle
//  rd_data    out  DATA_W  last completed read word; held until the next word completes
//  rd_valid   out  1       1-cycle pulse: rd_data updated
//  init_done  out  1       power-up sequence finished
//  mem_ce     out  1       PSRAM chip enable, active-low
//  mem_sio_o  out  4       SIO output value
//  mem_sio_oe out  4       SIO output enable, per bit
//  mem_sio_i  in   4       SIO input value
// BEHAVIOUR
//  Reset values (async, immediate):
//   mem_ce=1, mem_sio_oe=0, mem_sio_o=0, cmd_ready=0, init_done=0,
//   wr_ready=0, rd_valid=0, rd_data=0; state=INIT_WAIT; counters cleared.
//  FSM states:
//   INIT_WAIT->SPI_CMD(x3)->IDLE->Q_CMD->Q_ADDR->[Q_WAIT]->Q_DATA->Q_END->IDLE
//  INIT_WAIT:
//   - count INIT_CYCLES cycles with CE high, then issue the 3 SPI commands in order.
//  SPI_CMD:
//   - CE low for exactly 8 cycles; command bit on mem_sio_o[0], MSB first; oe=4'b0001.
//   - Then CE high and oe=0 for 2 cycles before the next command.
//   - After 0x35 plus its 2-cycle gap: init_done=1 (sticky until reset); go to IDLE.
//  IDLE:
//   - cmd_ready=1 only in IDLE with init_done=1.
//   - Accept on cmd_valid&&cmd_ready; latch addr, len, write; cmd_ready falls the next cycle.
//   - Write: the accept cycle is also a wr_ready cycle (word 0 captured).
//  Q_CMD:
//   - 2 cycles, oe=4'hF; nibbles of 0xEB (read) or 0x38 (write), high nibble first.
//   - CE falls in the first Q_CMD cycle.
//  Q_ADDR:
//   - 6 cycles, oe=4'hF; addr[23:20] first through addr[3:0].
//  Q_WAIT (read only):
//   - READ_WAIT cycles; oe=0 from the first wait cycle (bus turnaround).
//  Q_DATA write:
//   - oe=4'hF; DATA_W/4 nibbles per word, MSB nibble first.
//   - wr_ready pulses on the last nibble cycle of words 0..len-1, capturing the next word.
//   - No backpressure: the source must present the next word whenever wr_ready=1.
//  Q_DATA read:
//   - oe=0; shift mem_sio_i into the shift register MSB first.
//   - On each completed word: rd_data<=word and rd_valid=1 for exactly 1 cycle.
//  Q_END:
//   - CE high, oe=0 for 2 cycles; then IDLE with cmd_ready=1.
//  CE-low length per command (N = cmd_len+1):
//   - write: 8+N*DATA_W/4 cycles
//   - read:  8+READ_WAIT+N*DATA_W/4 cycles
//  Boundary conditions:
//   - cmd_valid during init or a busy state: ignored, not queued; the source holds it.
//   - cmd_len=0: single word. cmd_len > MAX_BURST-1: clamped to MAX_BURST-1.
//   - No page-boundary split: bursts crossing a 1KB page follow the PSRAM's wrap rules; callers must avoid this.
//   - rst mid-burst: CE high and oe=0 immediately; partial word discarded; full init sequence reruns.
//   - mem_sio_i is ignored whenever oe!=0.
// TESTING
//  T1 reset release, INIT_CYCLES=100:
//     CE high 100 cycles; three 8-cycle CE-low frames serialising 0x66, 0x99, 0x35 on sio_o[0],
//     2-cycle gaps; then init_done=1 and cmd_ready=1.
//  T2 write addr=0x012345 len=0 wr_data=0xBEEF:
//     sio_o beats 3,8,0,1,2,3,4,5,B,E,E,F; oe=F throughout; CE low 12 cycles;
//     exactly 1 wr_ready (accept cycle).
//  T3 read addr=0x000010 len=1, model returns 0xCAFE,0x1234:
//     E,B,0,0,0,0,1,0 then oe=0; CE low 22 cycles;
//     rd_valid pulses with rd_data=CAFE then 1234, 4 cycles apart.
//  T4 write len=3 (4 words, words 0xA0A0..0xA3A3):
//     4 wr_ready pulses (accept cycle, then 3 spaced every 4 cycles);
//     nibble stream matches words in order; CE low 24 cycles.
//  T5 cmd_valid held high from reset and during a burst:
//     no accept before init_done or before Q_END completes; exactly one accept per cmd_ready window.
//  T6 rst asserted at 3rd data nibble of a read:
//     same-cycle CE=1, oe=0, rd_valid never pulses; init sequence restarts from INIT_WAIT.

Source files
------------

// File: rtl/psram_qpi_ctrl.sv
// QPI PSRAM controller: runs the power-up sequence (delay, RSTEN, RST, SPI2QPI) itself,
// then serves valid/ready read/write bursts over split SIO out/oe/in pins. All logic is posedge mem_clk.
module psram_qpi_ctrl #(
    parameter int DATA_W      = 16,
    parameter int INIT_CYCLES = 12800,
    parameter int READ_WAIT   = 6,
    parameter int MAX_BURST   = 8,
    parameter int LEN_W       = 3
) (
    input  logic              mem_clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [23:0]       cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              init_done,
    output logic              mem_ce,
    output logic [3:0]        mem_sio_o,
    output logic [3:0]        mem_sio_oe,
    input  logic [3:0]        mem_sio_i
);

    localparam int NIBS      = DATA_W / 4;
    localparam int NIB_W     = (NIBS > 1) ? $clog2(NIBS) : 1;
    localparam int CNT_MAX_A = (INIT_CYCLES > READ_WAIT) ? INIT_CYCLES : READ_WAIT;
    localparam int CNT_MAX   = (CNT_MAX_A > 8) ? CNT_MAX_A : 8;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(READ_WAIT - 1);
    localparam logic [NIB_W-1:0] NIB_LAST  = NIB_W'(NIBS - 1);
    localparam logic [LEN_W-1:0] MAX_LEN   = LEN_W'(MAX_BURST - 1);

    typedef enum logic [3:0] {
        INIT_WAIT,
        SPI_CMD,
        SPI_GAP,
        IDLE,
        Q_CMD,
        Q_ADDR,
        Q_WAIT,
        Q_DATA,
        Q_END
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [1:0]        spi_idx;
    logic [NIB_W-1:0]  nib_cnt;
    logic [LEN_W-1:0]  word_cnt;
    logic [LEN_W-1:0]  len_r;
    logic [23:0]       addr_r;
    logic              write_r;
    logic [DATA_W-1:0] shift_r;

    logic              accept;
    logic              nib_last;
    logic [LEN_W-1:0]  len_clamp;
    logic [7:0]        spi_byte;
    logic [7:0]        qpi_cmd;
    logic [23:0]       addr_sh;
    logic [DATA_W-1:0] rd_shift;

    assign accept    = (state == IDLE) && init_done && cmd_valid;
    assign nib_last  = (nib_cnt == NIB_LAST);
    assign len_clamp = (cmd_len > MAX_LEN) ? MAX_LEN : cmd_len;
    assign qpi_cmd   = write_r ? 8'h38 : 8'hEB;
    assign addr_sh   = addr_r << {cnt[2:0], 2'b00};
    assign rd_shift  = (shift_r << 4) | DATA_W'(mem_sio_i);

    always_comb begin
        case (spi_idx)
            2'd0:    spi_byte = 8'h66;
            2'd1:    spi_byte = 8'h99;
            default: spi_byte = 8'h35;
        endcase
    end

    // The step counter restarts on every state change, so each state sees cnt=0 on entry.
    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            state     <= INIT_WAIT;
            cnt       <= '0;
            spi_idx   <= '0;
            nib_cnt   <= '0;
            word_cnt  <= '0;
            len_r     <= '0;
            addr_r    <= '0;
            write_r   <= 1'b0;
            shift_r   <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            init_done <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= (state_next != state) ? '0 : cnt + 1'b1;
            rd_valid <= 1'b0;

            if (state == SPI_GAP && cnt == CNT_W'(1)) begin
                if (spi_idx == 2'd2) begin
                    init_done <= 1'b1;
                end else begin
                    spi_idx <= spi_idx + 1'b1;
                end
            end

            if (accept) begin
                addr_r   <= cmd_addr;
                len_r    <= len_clamp;
                write_r  <= cmd_write;
                word_cnt <= '0;
                if (cmd_write) begin
                    shift_r <= wr_data;
                end
            end

            if (state == Q_DATA) begin
                nib_cnt <= nib_last ? '0 : nib_cnt + 1'b1;
                if (nib_last) begin
                    word_cnt <= word_cnt + 1'b1;
                end
                if (write_r) begin
                    shift_r <= wr_ready ? wr_data : (shift_r << 4);
                end else begin
                    shift_r <= rd_shift;
                    if (nib_last) begin
                        rd_data  <= rd_shift;
                        rd_valid <= 1'b1;
                    end
                end
            end else begin
                nib_cnt <= '0;
            end
        end
    end

    // Pin values are decoded from state so a reset forces CE high and releases the bus at once.
    always_comb begin
        state_next = state;
        mem_ce     = 1'b1;
        mem_sio_o  = 4'h0;
        mem_sio_oe = 4'h0;
        cmd_ready  = 1'b0;
        wr_ready   = 1'b0;

        case (state)
            INIT_WAIT: begin
                if (cnt == INIT_LAST) begin
                    state_next = SPI_CMD;
                end
            end
            SPI_CMD: begin
                mem_ce       = 1'b0;
                mem_sio_oe   = 4'b0001;
                mem_sio_o[0] = spi_byte[~cnt[2:0]];
                if (cnt[2:0] == 3'd7) begin
                    state_next = SPI_GAP;
                end
            end
            SPI_GAP: begin
                if (cnt == CNT_W'(1)) begin
                    state_next = (spi_idx == 2'd2) ? IDLE : SPI_CMD;
                end
            end
            IDLE: begin
                cmd_ready = init_done;
                wr_ready  = accept && cmd_write;
                if (accept) begin
                    state_next = Q_CMD;
                end
            end
            Q_CMD: begin
                mem_ce     = 1'b0;
                mem_sio_oe = 4'hF;
                mem_sio_o  = cnt[0] ? qpi_cmd[3:0] : qpi_cmd[7:4];
                if (cnt == CNT_W'(1)) begin
                    state_next = Q_ADDR;
                end
            end
            Q_ADDR: begin
                mem_ce     = 1'b0;
                mem_sio_oe = 4'hF;
                mem_sio_o  = addr_sh[23:20];
                if (cnt == CNT_W'(5)) begin
                    state_next = (write_r || READ_WAIT == 0) ? Q_DATA : Q_WAIT;
                end
            end
            Q_WAIT: begin
                mem_ce = 1'b0;
                if (cnt == WAIT_LAST) begin
                    state_next = Q_DATA;
                end
            end
            Q_DATA: begin
                mem_ce = 1'b0;
                if (write_r) begin
                    mem_sio_oe = 4'hF;
                    mem_sio_o  = shift_r[DATA_W-1 -: 4];
                    wr_ready   = nib_last && (word_cnt != len_r);
                end
                if (nib_last && word_cnt == len_r) begin
                    state_next = Q_END;
                end
            end
            Q_END: begin
                if (cnt == CNT_W'(1)) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = INIT_WAIT;
            end
        endcase
    end

endmodule

// File: tb/tb_psram_qpi_ctrl.sv
// Directed bench for psram_qpi_ctrl: power-up sequence, a table of read/write bursts checked
// against hand-computed pin streams, held cmd_valid handling and reset in the middle of a read.
module tb_psram_qpi_ctrl;

    localparam int DATA_W      = 16;
    localparam int INIT_CYCLES = 100;
    localparam int READ_WAIT   = 6;
    localparam int MAX_BURST   = 8;
    localparam int LEN_W       = 3;
    localparam int NVEC        = 6;

    logic              mem_clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_write = 1'b0;
    logic [23:0]       cmd_addr = '0;
    logic [LEN_W-1:0]  cmd_len = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              wr_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              init_done;
    logic              mem_ce;
    logic [3:0]        mem_sio_o;
    logic [3:0]        mem_sio_oe;
    logic [3:0]        mem_sio_i = '0;

    int total = 0;
    int bad = 0;

    typedef struct {
        bit          wr;
        logic [23:0] addr;
        logic [2:0]  len;
        logic [15:0] words[8];
        int          exp_ce;
        int          exp_nibs;
        logic [95:0] exp_stream;
        int          exp_pulses;
    } vec_t;

    vec_t       vecs[NVEC];
    logic [7:0] spi_exp[3];

    psram_qpi_ctrl #(
        .DATA_W(DATA_W),
        .INIT_CYCLES(INIT_CYCLES),
        .READ_WAIT(READ_WAIT),
        .MAX_BURST(MAX_BURST),
        .LEN_W(LEN_W)
    ) dut (
        .mem_clk(mem_clk),
        .rst(rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr(cmd_addr),
        .cmd_len(cmd_len),
        .wr_data(wr_data),
        .wr_ready(wr_ready),
        .rd_data(rd_data),
        .rd_valid(rd_valid),
        .init_done(init_done),
        .mem_ce(mem_ce),
        .mem_sio_o(mem_sio_o),
        .mem_sio_oe(mem_sio_oe),
        .mem_sio_i(mem_sio_i)
    );

    always #5 mem_clk = ~mem_clk;

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [95:0] actual, input logic [95:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 300) begin
            @(negedge mem_clk);
            mem_sio_i = 4'($urandom);
            #1;
            n++;
        end
        checkOutput("wait_ready", cmd_ready, 1);
    endtask

    // Called right after rst falls at a negedge; returns at the sample point of the first IDLE cycle.
    task automatic check_init();
        int         high_cnt;
        int         frame_bad;
        int         gap_bad;
        bit         stray;
        logic [7:0] got;
        high_cnt = 0;
        gap_bad  = 0;
        stray    = 0;
        #1;
        while (mem_ce === 1'b1 && high_cnt < 1000) begin
            if (cmd_ready || init_done || wr_ready || rd_valid || mem_sio_oe != 4'h0) stray = 1;
            high_cnt++;
            @(negedge mem_clk);
            #1;
        end
        checkOutput("init_delay", high_cnt, INIT_CYCLES);
        for (int f = 0; f < 3; f++) begin
            got       = '0;
            frame_bad = 0;
            for (int b = 0; b < 8; b++) begin
                if (mem_ce !== 1'b0 || mem_sio_oe !== 4'b0001) frame_bad++;
                if (cmd_ready || init_done || wr_ready || rd_valid) stray = 1;
                got = {got[6:0], mem_sio_o[0]};
                @(negedge mem_clk);
                #1;
            end
            checkOutput("spi_byte", got, spi_exp[f]);
            checkOutput("spi_frame_pins", frame_bad, 0);
            for (int g = 0; g < 2; g++) begin
                if (mem_ce !== 1'b1 || mem_sio_oe !== 4'h0) gap_bad++;
                if (cmd_ready || init_done || wr_ready || rd_valid) stray = 1;
                @(negedge mem_clk);
                #1;
            end
        end
        checkOutput("spi_gaps", gap_bad, 0);
        checkOutput("init_no_stray", stray, 0);
        checkOutput("init_done", init_done, 1);
        checkOutput("idle_ready", cmd_ready, 1);
    endtask

    task automatic applyStimulus(input vec_t v);
        int          cyc;
        int          ce_cnt;
        int          nib_cnt;
        int          wr_p;
        int          rd_p;
        int          last_wr;
        int          last_rd;
        int          space_bad;
        int          oe_bad;
        int          ready_bad;
        int          hi_after;
        int          b;
        bit          accepted;
        bit          acc_prev;
        bit          done;
        logic [95:0] stream;
        logic [15:0] w;
        cyc = 0; ce_cnt = 0; nib_cnt = 0; wr_p = 0; rd_p = 0;
        last_wr = 0; last_rd = 0; space_bad = 0; oe_bad = 0; ready_bad = 0;
        hi_after = 0; accepted = 0; acc_prev = 0; done = 0; stream = '0;
        wait_ready();
        @(negedge mem_clk);
        cmd_valid = 1'b1;
        cmd_write = v.wr;
        cmd_addr  = v.addr;
        cmd_len   = v.len;
        wr_data   = v.words[0];
        mem_sio_i = 4'($urandom);
        #1;
        while (!done && cyc < 300) begin
            if (acc_prev && cmd_ready) ready_bad++;
            acc_prev = 0;
            if (!accepted && cmd_ready && cmd_valid) begin
                accepted = 1;
                acc_prev = 1;
            end
            if (wr_ready) begin
                wr_p++;
                if (wr_p >= 3 && cyc - last_wr != 4) space_bad++;
                last_wr = cyc;
            end
            if (rd_valid) begin
                if (rd_p < 8) checkOutput("rd_word", rd_data, v.words[rd_p]);
                rd_p++;
                if (rd_p >= 2 && cyc - last_rd != 4) space_bad++;
                last_rd = cyc;
            end
            if (mem_ce === 1'b0) ce_cnt++;
            if (mem_sio_oe === 4'hF) begin
                stream = {stream[91:0], mem_sio_o};
                nib_cnt++;
            end else if (mem_sio_oe !== 4'h0) begin
                oe_bad++;
            end
            if (ce_cnt > 0 && mem_ce === 1'b1) hi_after++;
            if (ce_cnt > 0 && mem_ce === 1'b1 && cmd_ready === 1'b1) done = 1;
            if (!done) begin
                @(negedge mem_clk);
                cyc++;
                if (accepted) cmd_valid = 1'b0;
                wr_data = (wr_p < 8) ? v.words[wr_p] : 16'h0;
                if (!v.wr && ce_cnt >= 8 + READ_WAIT && ce_cnt < 8 + READ_WAIT + 4 * (int'(v.len) + 1)) begin
                    b = ce_cnt - 8 - READ_WAIT;
                    w = v.words[b / 4];
                    mem_sio_i = w[15 - 4 * (b % 4) -: 4];
                end else begin
                    mem_sio_i = 4'($urandom);
                end
                #1;
            end
        end
        checkOutput("burst_done", done, 1);
        checkOutput("ce_low_len", ce_cnt, v.exp_ce);
        checkOutput("out_nibbles", nib_cnt, v.exp_nibs);
        checkOutput("out_stream", stream, v.exp_stream);
        checkOutput("strobe_count", wr_p + rd_p, v.exp_pulses);
        checkOutput("wrong_strobe", v.wr ? rd_p : wr_p, 0);
        checkOutput("strobe_spacing", space_bad, 0);
        checkOutput("oe_pattern", oe_bad, 0);
        checkOutput("ready_drop", ready_bad, 0);
        checkOutput("end_gap", hi_after, 3);
    endtask

    initial begin
        int acc_cyc[2];
        int accepts;
        int ready_busy;
        int cyc;
        int ce_cnt;
        int rdv;

        spi_exp = '{8'h66, 8'h99, 8'h35};

        vecs[0].wr = 1; vecs[0].addr = 24'h012345; vecs[0].len = 3'd0;
        vecs[0].words = '{16'hBEEF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        vecs[0].exp_ce = 12; vecs[0].exp_nibs = 12;
        vecs[0].exp_stream = 96'h38012345BEEF; vecs[0].exp_pulses = 1;

        vecs[1].wr = 0; vecs[1].addr = 24'h000010; vecs[1].len = 3'd1;
        vecs[1].words = '{16'hCAFE, 16'h1234, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        vecs[1].exp_ce = 22; vecs[1].exp_nibs = 8;
        vecs[1].exp_stream = 96'hEB000010; vecs[1].exp_pulses = 2;

        vecs[2].wr = 1; vecs[2].addr = 24'h00ABCD; vecs[2].len = 3'd3;
        vecs[2].words = '{16'hA0A0, 16'hA1A1, 16'hA2A2, 16'hA3A3, 16'h0, 16'h0, 16'h0, 16'h0};
        vecs[2].exp_ce = 24; vecs[2].exp_nibs = 24;
        vecs[2].exp_stream = 96'h3800ABCDA0A0A1A1A2A2A3A3; vecs[2].exp_pulses = 4;

        vecs[3].wr = 0; vecs[3].addr = 24'hFEDCBA; vecs[3].len = 3'd0;
        vecs[3].words = '{16'h5A5A, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        vecs[3].exp_ce = 18; vecs[3].exp_nibs = 8;
        vecs[3].exp_stream = 96'hEBFEDCBA; vecs[3].exp_pulses = 1;

        vecs[4].wr = 1; vecs[4].addr = 24'h7FFFF0; vecs[4].len = 3'd1;
        vecs[4].words = '{16'h0001, 16'hFFFE, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        vecs[4].exp_ce = 16; vecs[4].exp_nibs = 16;
        vecs[4].exp_stream = 96'h387FFFF00001FFFE; vecs[4].exp_pulses = 2;

        vecs[5].wr = 0; vecs[5].addr = 24'h000100; vecs[5].len = 3'd7;
        vecs[5].words = '{16'h0001, 16'h0010, 16'h0100, 16'h1000, 16'hFFFF, 16'h0000, 16'h8421, 16'h7BDE};
        vecs[5].exp_ce = 46; vecs[5].exp_nibs = 8;
        vecs[5].exp_stream = 96'hEB000100; vecs[5].exp_pulses = 8;

        // Reset values, with a read request already held from reset onwards
        rst = 1'b1;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr = 24'h0;
        cmd_len = 3'd0;
        repeat (3) @(negedge mem_clk);
        #1;
        checkOutput("rst_ce", mem_ce, 1);
        checkOutput("rst_oe", mem_sio_oe, 0);
        checkOutput("rst_sio_o", mem_sio_o, 0);
        checkOutput("rst_ready", cmd_ready, 0);
        checkOutput("rst_init_done", init_done, 0);
        checkOutput("rst_wr_ready", wr_ready, 0);
        checkOutput("rst_rd", {rd_valid, rd_data}, 0);
        @(negedge mem_clk);
        rst = 1'b0;
        check_init();

        // Held cmd_valid: one accept per ready window, none while busy
        accepts = 0;
        ready_busy = 0;
        cyc = 0;
        acc_cyc = '{0, 0};
        while (accepts < 2 && cyc < 200) begin
            if (cmd_ready && cmd_valid) begin
                acc_cyc[accepts] = cyc;
                accepts++;
            end
            if (cmd_ready && !mem_ce) ready_busy++;
            @(negedge mem_clk);
            cyc++;
            if (accepts == 2) cmd_valid = 1'b0;
            mem_sio_i = 4'($urandom);
            #1;
        end
        checkOutput("held_accepts", accepts, 2);
        checkOutput("held_spacing", acc_cyc[1] - acc_cyc[0], 21);
        checkOutput("held_ready_drop", cmd_ready, 0);
        checkOutput("held_ready_busy", ready_busy, 0);

        for (int i = 0; i < NVEC; i++) begin
            $display("[TB] vector %0d", i);
            applyStimulus(vecs[i]);
        end

        // Reset on the third data nibble of a read
        wait_ready();
        @(negedge mem_clk);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr = 24'h000020;
        cmd_len = 3'd1;
        #1;
        ce_cnt = 0;
        cyc = 0;
        rdv = 0;
        while (ce_cnt < 8 + READ_WAIT + 2 && cyc < 100) begin
            if (rd_valid) rdv++;
            if (mem_ce === 1'b0) ce_cnt++;
            @(negedge mem_clk);
            cyc++;
            cmd_valid = 1'b0;
            mem_sio_i = 4'($urandom);
            #1;
        end
        checkOutput("mid_read_ce", mem_ce, 0);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_ce", mem_ce, 1);
        checkOutput("mid_rst_oe", mem_sio_oe, 0);
        checkOutput("mid_rst_flags", {rd_valid, init_done, cmd_ready}, 0);
        repeat (2) begin
            @(negedge mem_clk);
            #1;
            if (rd_valid) rdv++;
        end
        checkOutput("mid_rst_no_rd_valid", rdv, 0);
        @(negedge mem_clk);
        rst = 1'b0;
        check_init();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
